// File: rtl/pwm_config_seq_pkg.sv
// Shared definitions for the PWM configuration sequencer: state encoding,
// idle values of the peripheral bus and parameter legality helpers.
package pwm_config_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int   IDLE_ADDRESS      = 0;
    localparam int   IDLE_DATA         = 0;
    localparam logic IDLE_WRITE_EN     = 1'b0;
    localparam int   MAX_READ_LATENCY  = 3;

    // The per-address hold counter is 2 bits wide, which bounds the latency.
    function automatic bit read_latency_legal(input int latency);
        return (latency >= 0) && (latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/pwm_config_shadow_regs.sv
// Shadow image of the peripheral registers: one synchronous write port and
// one combinational read port; writes to addresses past the image are lost.
module pwm_config_shadow_regs #(
    parameter int ADDRESS_SIZE = 6,
    parameter int DATA_SIZE    = 8,
    parameter int LOCATIONS    = 49
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_we,
    input  logic [ADDRESS_SIZE-1:0] i_waddr,
    input  logic [DATA_SIZE-1:0]    i_wdata,
    input  logic [ADDRESS_SIZE-1:0] i_raddr,
    output logic [DATA_SIZE-1:0]    o_rdata
);

    logic [LOCATIONS*DATA_SIZE-1:0] w_image;

    genvar gi;
    generate
        for (gi = 0; gi < LOCATIONS; gi++) begin : g_loc
            logic [DATA_SIZE-1:0] r_word;

            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    r_word <= '0;
                end else if (i_we && (i_waddr == ADDRESS_SIZE'(gi))) begin
                    r_word <= i_wdata;
                end
            end

            assign w_image[gi*DATA_SIZE +: DATA_SIZE] = r_word;
        end
    endgenerate

    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < LOCATIONS; i++) begin
            if (i_raddr == ADDRESS_SIZE'(i)) begin
                o_rdata = w_image[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

endmodule

// File: rtl/pwm_config_sequencer.sv
// Streams the shadow register image into the PWM peripheral on commit and
// optionally reads it back, flagging the first location that differs.
module pwm_config_sequencer
    import pwm_config_seq_pkg::*;
#(
    parameter int ADDRESS_SIZE = 6,
    parameter int DATA_SIZE    = 8,
    parameter int LOCATIONS    = 49,
    parameter int READ_LATENCY = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_host_we,
    input  logic [ADDRESS_SIZE-1:0] i_host_addr,
    input  logic [DATA_SIZE-1:0]    i_host_data,
    input  logic                    i_start,
    input  logic                    i_verify_en,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [ADDRESS_SIZE-1:0] o_error_address,
    output logic [ADDRESS_SIZE-1:0] o_address,
    output logic [DATA_SIZE-1:0]    o_data,
    output logic                    o_write_en,
    input  logic [DATA_SIZE-1:0]    i_data
);

    generate
        if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
            $error("pwm_config_sequencer: READ_LATENCY must be in 0..3");
        end
        if (LOCATIONS > (1 << ADDRESS_SIZE)) begin : g_bad_locations
            $error("pwm_config_sequencer: LOCATIONS exceeds the address space");
        end
    endgenerate

    localparam logic [ADDRESS_SIZE-1:0] LAST_INDEX = ADDRESS_SIZE'(LOCATIONS - 1);
    localparam logic [1:0]              LAST_LAT   = 2'(READ_LATENCY);

    seq_state_t              r_state, w_state_next;
    logic [ADDRESS_SIZE-1:0] r_index, w_index_next;
    logic [1:0]              r_lat, w_lat_next;
    logic                    r_verify, w_verify_next;
    logic                    r_error, w_error_next;
    logic [ADDRESS_SIZE-1:0] r_error_address, w_error_address_next;
    logic [DATA_SIZE-1:0]    w_shadow_data;
    logic                    w_shadow_we;

    // Freezing the image outside IDLE keeps write-out and readback consistent.
    assign w_shadow_we = (r_state == ST_IDLE) && i_host_we;

    pwm_config_shadow_regs #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .DATA_SIZE    (DATA_SIZE),
        .LOCATIONS    (LOCATIONS)
    ) u_shadow (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_we      (w_shadow_we),
        .i_waddr   (i_host_addr),
        .i_wdata   (i_host_data),
        .i_raddr   (r_index),
        .o_rdata   (w_shadow_data)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= ST_IDLE;
            r_index         <= '0;
            r_lat           <= '0;
            r_verify        <= 1'b0;
            r_error         <= 1'b0;
            r_error_address <= '0;
        end else begin
            r_state         <= w_state_next;
            r_index         <= w_index_next;
            r_lat           <= w_lat_next;
            r_verify        <= w_verify_next;
            r_error         <= w_error_next;
            r_error_address <= w_error_address_next;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_index_next         = r_index;
        w_lat_next           = r_lat;
        w_verify_next        = r_verify;
        w_error_next         = r_error;
        w_error_address_next = r_error_address;
        o_busy               = 1'b0;
        o_done               = 1'b0;
        o_address            = ADDRESS_SIZE'(IDLE_ADDRESS);
        o_data               = DATA_SIZE'(IDLE_DATA);
        o_write_en           = IDLE_WRITE_EN;

        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next         = ST_WRITE;
                    w_index_next         = '0;
                    w_lat_next           = '0;
                    w_verify_next        = i_verify_en;
                    w_error_next         = 1'b0;
                    w_error_address_next = '0;
                end
            end
            ST_WRITE: begin
                o_busy     = 1'b1;
                o_address  = r_index;
                o_data     = w_shadow_data;
                o_write_en = 1'b1;
                if (r_index == LAST_INDEX) begin
                    w_index_next = '0;
                    w_lat_next   = '0;
                    w_state_next = r_verify ? ST_READ : ST_DONE;
                end else begin
                    w_index_next = r_index + 1'b1;
                end
            end
            ST_READ: begin
                o_busy    = 1'b1;
                o_address = r_index;
                // Compare only on the last cycle of the hold window.
                if (r_lat == LAST_LAT) begin
                    w_lat_next = '0;
                    if (i_data != w_shadow_data) begin
                        w_error_next         = 1'b1;
                        w_error_address_next = r_index;
                        w_index_next         = '0;
                        w_state_next         = ST_DONE;
                    end else if (r_index == LAST_INDEX) begin
                        w_index_next = '0;
                        w_state_next = ST_DONE;
                    end else begin
                        w_index_next = r_index + 1'b1;
                    end
                end else begin
                    w_lat_next = r_lat + 1'b1;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign o_error         = r_error;
    assign o_error_address = r_error_address;

endmodule
